// File: rtl/alu_pkg.sv
// Shared opcode values and FSM state encoding for the multicycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_XNOR = 4'b1100;
    localparam logic [3:0] OP_MULU = 4'b1000;
    localparam logic [3:0] OP_DIVU = 4'b1010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2
    } alu_state_e;

endpackage

// File: rtl/alu_addsub.sv
// Adder/subtractor: a+b or a+~b+1, with carry (add) or borrow (sub) and signed overflow.
module alu_addsub #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             overflow
);

    logic [WIDTH-1:0] b_eff;
    logic             c_out;

    always_comb begin
        b_eff          = sub ? ~b : b;
        {c_out, sum}   = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
        // For subtraction the raw carry is "no borrow", so invert it
        carry          = sub ? ~c_out : c_out;
        overflow       = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end

endmodule

// File: rtl/alu_multicycle.sv
// Execute-stage ALU: single-cycle logic/arith ops plus iterative unsigned
// multiply (shift-add, LSB first) and restoring divide (MSB first).
module alu_multicycle
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic             zero,
    output logic             carry_out,
    output logic             overflow
);

    alu_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic             zero_q, zero_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             done_q, done_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] as_a, as_b, as_sum;
    logic             as_sub, as_carry, as_ovf;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_acc_nx, mul_opa_nx;
    logic [WIDTH-1:0] rem_sh, div_acc_nx, div_opa_nx;
    logic             div_ge, last_iter;

    alu_addsub #(.WIDTH(WIDTH)) u_addsub (
        .a        (as_a),
        .b        (as_b),
        .sub      (as_sub),
        .sum      (as_sum),
        .carry    (as_carry),
        .overflow (as_ovf)
    );

    always_comb begin
        // Shared adder: ALU operands when idle, divider trial subtract in DIV
        as_a   = a;
        as_b   = b;
        as_sub = (alu_ctrl == OP_SUB) || (alu_ctrl == OP_SLT);
        if (state_q == ST_DIV) begin
            as_a   = rem_sh;
            as_b   = opb_q;
            as_sub = 1'b1;
        end
    end

    always_comb begin
        mul_sum    = {1'b0, acc_q} + (opa_q[0] ? {1'b0, opb_q} : {(WIDTH + 1){1'b0}});
        mul_acc_nx = mul_sum[WIDTH:1];
        mul_opa_nx = {mul_sum[0], opa_q[WIDTH-1:1]};

        // The shifted remainder is WIDTH+1 bits; a set top bit always fits the divisor
        rem_sh     = {acc_q[WIDTH-2:0], opa_q[WIDTH-1]};
        div_ge     = acc_q[WIDTH-1] | ~as_carry;
        div_acc_nx = div_ge ? as_sum : rem_sh;
        div_opa_nx = {opa_q[WIDTH-2:0], div_ge};

        last_iter  = (cnt_q == CNT_W'(WIDTH - 1));
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        acc_d       = acc_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        ovf_d       = ovf_q;
        done_d      = 1'b0;
        busy_d      = busy_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if ((alu_ctrl == OP_MULU) || (alu_ctrl == OP_DIVU)) begin
                        state_d = (alu_ctrl == OP_MULU) ? ST_MUL : ST_DIV;
                        cnt_d   = '0;
                        opa_d   = a;
                        opb_d   = b;
                        acc_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        done_d      = 1'b1;
                        result_hi_d = '0;
                        carry_d     = 1'b0;
                        ovf_d       = 1'b0;
                        result_d    = '0;
                        case (alu_ctrl)
                            OP_AND:  result_d = a & b;
                            OP_OR:   result_d = a | b;
                            OP_XNOR: result_d = ~(a ^ b);
                            OP_ADD, OP_SUB: begin
                                result_d = as_sum;
                                carry_d  = as_carry;
                                ovf_d    = as_ovf;
                            end
                            OP_SLT: begin
                                result_d[0] = as_sum[WIDTH-1] ^ as_ovf;
                                ovf_d       = as_ovf;
                            end
                            default: result_d = '0;
                        endcase
                        zero_d = (result_d == '0);
                    end
                end
            end
            ST_MUL: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = mul_acc_nx;
                opa_d = mul_opa_nx;
                if (last_iter) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = mul_opa_nx;
                    result_hi_d = mul_acc_nx;
                    zero_d      = (mul_opa_nx == '0);
                    carry_d     = 1'b0;
                    ovf_d       = (mul_acc_nx != '0);
                end
            end
            ST_DIV: begin
                cnt_d = cnt_q + CNT_W'(1);
                acc_d = div_acc_nx;
                opa_d = div_opa_nx;
                if (last_iter) begin
                    state_d     = ST_IDLE;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = div_opa_nx;
                    result_hi_d = div_acc_nx;
                    zero_d      = (div_opa_nx == '0);
                    carry_d     = 1'b0;
                    ovf_d       = (opb_q == '0);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b1;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            ovf_q       <= ovf_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign result_hi = result_hi_q;
    assign zero      = zero_q;
    assign carry_out = carry_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Bench for alu_multicycle: directed and random ops on 32-bit and 8-bit
// instances against an arithmetic reference model.
module tb_alu_multicycle;

    localparam logic [3:0] T_AND  = 4'b0000;
    localparam logic [3:0] T_OR   = 4'b0001;
    localparam logic [3:0] T_ADD  = 4'b0010;
    localparam logic [3:0] T_SUB  = 4'b0110;
    localparam logic [3:0] T_SLT  = 4'b0111;
    localparam logic [3:0] T_XNOR = 4'b1100;
    localparam logic [3:0] T_MULU = 4'b1000;
    localparam logic [3:0] T_DIVU = 4'b1010;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        v;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        z;
        logic        c;
        logic        v;
        logic        busy;
        logic        done;
    } obs_t;

    logic        clk, rst;
    logic        start32, start8;
    logic [3:0]  ctrl32, ctrl8;
    logic [31:0] a32, b32, res32, hi32;
    logic [7:0]  a8, b8, res8, hi8;
    logic        busy32, done32, z32, c32, v32;
    logic        busy8, done8, z8, c8, v8;

    int total = 0;
    int bad   = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start32), .alu_ctrl(ctrl32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
        .zero(z32), .carry_out(c32), .overflow(v32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .alu_ctrl(ctrl8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
        .zero(z8), .carry_out(c8), .overflow(v8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on w-bit unsigned / two's-complement values
    function automatic exp_t model(input int w, input logic [3:0] op,
                                   input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        longint unsigned m, ua, ub, p;
        longint lim, sa, sb, sd;
        e   = '0;
        m   = (64'd1 << w) - 64'd1;
        ua  = {32'd0, a} & m;
        ub  = {32'd0, b} & m;
        lim = longint'(1) << (w - 1);
        sa  = (ua >= 64'(lim)) ? longint'(ua) - 2 * lim : longint'(ua);
        sb  = (ub >= 64'(lim)) ? longint'(ub) - 2 * lim : longint'(ub);
        case (op)
            T_AND:  e.res = 32'(ua & ub);
            T_OR:   e.res = 32'(ua | ub);
            T_XNOR: e.res = 32'(~(ua ^ ub) & m);
            T_ADD: begin
                e.res = 32'((ua + ub) & m);
                e.c   = (ua + ub) > m;
                sd    = sa + sb;
                e.v   = (sd >= lim) || (sd < -lim);
            end
            T_SUB: begin
                e.res = 32'((ua - ub) & m);
                e.c   = ua < ub;
                sd    = sa - sb;
                e.v   = (sd >= lim) || (sd < -lim);
            end
            T_SLT: begin
                e.res = (sa < sb) ? 32'd1 : 32'd0;
                sd    = sa - sb;
                e.v   = (sd >= lim) || (sd < -lim);
            end
            T_MULU: begin
                p     = ua * ub;
                e.res = 32'(p & m);
                e.hi  = 32'((p >> w) & m);
                e.v   = (e.hi != 32'd0);
                e.lat = w;
            end
            T_DIVU: begin
                if (ub == 0) begin
                    e.res = 32'(m);
                    e.hi  = 32'(ua);
                    e.v   = 1'b1;
                end else begin
                    e.res = 32'(ua / ub);
                    e.hi  = 32'(ua % ub);
                end
                e.lat = w;
            end
            default: e.res = 32'd0;
        endcase
        e.z = (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input int w, input logic st, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        if (w == 8) begin
            start8 = st; ctrl8 = op; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start32 = st; ctrl32 = op; a32 = a; b32 = b;
        end
    endtask

    task automatic sample(input int w, output obs_t o);
        if (w == 8)
            o = '{res: {24'd0, res8}, hi: {24'd0, hi8}, z: z8, c: c8, v: v8, busy: busy8, done: done8};
        else
            o = '{res: res32, hi: hi32, z: z32, c: c32, v: v32, busy: busy32, done: done32};
    endtask

    // Issue one op, scramble inputs while busy, optionally pulse a stray start,
    // then check latency, outputs and (unless b2b) the one-cycle done pulse.
    task automatic run(input int w, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input string tag, input int inject, input bit b2b);
        exp_t e;
        obs_t o;
        int   cyc;
        logic busy_ok;
        e = model(w, op, a, b);
        @(negedge clk);
        drive(w, 1'b1, op, a, b);
        @(posedge clk); #1;
        drive(w, 1'b0, op, a, b);
        cyc     = 0;
        busy_ok = 1'b1;
        sample(w, o);
        while (!o.done && cyc < 200) begin
            if (o.busy !== 1'b1) busy_ok = 1'b0;
            drive(w, cyc == inject, (cyc == inject) ? T_ADD : 4'($urandom), $urandom, $urandom);
            @(posedge clk); #1;
            cyc++;
            sample(w, o);
        end
        drive(w, 1'b0, T_AND, 32'd0, 32'd0);
        chk({tag, ".lat"}, 64'(cyc), 64'(e.lat));
        chk({tag, ".busy_run"}, 64'(busy_ok), 64'd1);
        chk({tag, ".busy_end"}, 64'(o.busy), 64'd0);
        chk({tag, ".res"}, 64'(o.res), 64'(e.res));
        chk({tag, ".hi"}, 64'(o.hi), 64'(e.hi));
        chk({tag, ".zero"}, 64'(o.z), 64'(e.z));
        chk({tag, ".carry"}, 64'(o.c), 64'(e.c));
        chk({tag, ".ovf"}, 64'(o.v), 64'(e.v));
        if (!b2b) begin
            @(posedge clk); #1;
            sample(w, o);
            chk({tag, ".pulse"}, 64'(o.done), 64'd0);
            chk({tag, ".hold"}, 64'(o.res), 64'(e.res));
        end
    endtask

    task automatic chk_reset(input int w, input string tag);
        obs_t o;
        sample(w, o);
        chk({tag, ".busy"}, 64'(o.busy), 64'd0);
        chk({tag, ".done"}, 64'(o.done), 64'd0);
        chk({tag, ".res"}, 64'(o.res), 64'd0);
        chk({tag, ".hi"}, 64'(o.hi), 64'd0);
        chk({tag, ".zero"}, 64'(o.z), 64'd1);
        chk({tag, ".carry"}, 64'(o.c), 64'd0);
        chk({tag, ".ovf"}, 64'(o.v), 64'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        logic [3:0] ops [10];
        logic       seen_done;
        ops = '{T_AND, T_OR, T_ADD, T_SUB, T_SLT, T_XNOR, T_MULU, T_DIVU, 4'b0011, 4'b1111};

        rst = 1'b1;
        drive(32, 1'b0, T_AND, 32'd0, 32'd0);
        drive(8, 1'b0, T_AND, 32'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        chk_reset(32, "reset32");
        chk_reset(8, "reset8");
        @(negedge clk);
        rst = 1'b0;

        run(32, T_ADD, 32'h7FFF_FFFF, 32'h1, "add_ovf", -1, 1'b0);
        run(32, T_SUB, 32'd5, 32'd7, "sub_borrow", -1, 1'b0);
        run(32, T_SLT, 32'h8000_0000, 32'd1, "slt_neg", -1, 1'b0);
        run(32, T_SLT, 32'd1, 32'h8000_0000, "slt_pos", -1, 1'b0);
        run(32, T_MULU, 32'h0001_0000, 32'h0001_0000, "mul_hi", -1, 1'b0);
        run(32, T_DIVU, 32'd100, 32'd7, "div", -1, 1'b0);
        run(32, T_DIVU, 32'd5, 32'd0, "div0", -1, 1'b0);
        run(32, T_MULU, 32'h0000_1234, 32'h0009_8765, "mul_stray", 5, 1'b0);

        // Reset ten cycles into a multiply: everything clears and no done follows
        @(negedge clk);
        drive(32, 1'b1, T_MULU, 32'hDEAD_BEEF, 32'h1234_5678);
        @(posedge clk); #1;
        drive(32, 1'b0, T_AND, 32'd0, 32'd0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_reset(32, "rst_mid");
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done32 !== 1'b0 || busy32 !== 1'b0) seen_done = 1'b1;
        end
        chk("rst_mid.quiet", 64'(seen_done), 64'd0);
        run(32, T_ADD, 32'd3, 32'd4, "add_after_rst", -1, 1'b0);

        run(32, T_DIVU, 32'hFFFF_FFF0, 32'd3, "div_b2b", -1, 1'b1);
        run(32, T_XNOR, 32'hF0F0_F0F0, 32'hF0F0_F0F0, "xnor_b2b", -1, 1'b0);
        run(32, 4'b0101, 32'h1234, 32'h5678, "illegal_op", -1, 1'b0);

        run(8, T_MULU, 32'hFF, 32'hFF, "mul8_ff", -1, 1'b0);
        run(8, T_DIVU, 32'hC8, 32'h00, "div8_0", -1, 1'b0);

        for (int i = 0; i < 30; i++)
            run(32, ops[$urandom_range(0, 9)], pick_operand(), pick_operand(), "rand32", -1, 1'b0);
        for (int i = 0; i < 12; i++)
            run(8, ops[$urandom_range(0, 9)], $urandom, $urandom, "rand8", -1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
